digit_decider: RTL and testbench

// - Reader side of the sigmoid register file: consumes the 10 output-neuron values (digit_weights).
// - Picks the recognized digit with a sequential argmax scan.
// - Captures a snapshot of all weights when start is accepted, scans one digit per clock, then

---
 rtl/digit_decider_pkg.sv | 23 ++
 rtl/digit_decider_snapshot.sv | 31 +++
 rtl/digit_decider.sv | 114 +++++++++++
 tb/tb_digit_decider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_decider_pkg.sv
// Shared constants and types for the digit decider and the sigmoid register file it reads.
package digit_decider_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int WEIGHT_W   = 4;
  localparam int IDX_W      = 4;

  typedef logic [WEIGHT_W-1:0]          weight_t;
  typedef logic [IDX_W-1:0]             digit_idx_t;
  typedef weight_t [0:NUM_DIGITS-1]     weight_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } decider_state_t;

  // Ties keep the earlier digit, so only a strictly larger value takes the lead.
  function automatic logic takes_lead(input weight_t cand, input weight_t best, input logic first);
    return first || (cand > best);
  endfunction

endpackage

// File: rtl/digit_decider_snapshot.sv
// Capture register for all digit weights, loaded once per decision and read one digit at a time.
module digit_decider_snapshot
  import digit_decider_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load_i,
  input  weight_vec_t data_i,
  input  digit_idx_t  rd_idx_i,
  output weight_t     rd_data_o
);

  weight_vec_t snap_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      snap_q <= '0;
    end else if (load_i) begin
      snap_q <= data_i;
    end
  end

  // Out-of-range indices read as zero rather than undefined.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_data_o = snap_q[i];
    end
  end

endmodule

// File: rtl/digit_decider.sv
// Sequential argmax over the output-neuron values: one digit per clock, then a one-cycle result pulse.
//
// state | meaning
// IDLE  | waiting for start; snapshot and threshold captured on accept
// SCAN  | comparing snapshot[idx] against the running best, idx = 0..NUM_DIGITS-1
// DONE  | result registered, done pulse high for this cycle
module digit_decider
  import digit_decider_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 start,
  input  logic [0:NUM_DIGITS-1][WEIGHT_W-1:0]  digit_weights,
  input  logic [WEIGHT_W-1:0]                  threshold,
  output logic                                 busy,
  output logic                                 done,
  output logic [IDX_W-1:0]                     digit,
  output logic [WEIGHT_W-1:0]                  confidence,
  output logic                                 valid
);

  localparam digit_idx_t LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  decider_state_t state_q;
  digit_idx_t     idx_q;
  digit_idx_t     best_idx_q;
  weight_t        best_val_q;
  weight_t        thr_q;
  logic           busy_q;
  logic           done_q;
  digit_idx_t     digit_q;
  weight_t        conf_q;
  logic           valid_q;

  weight_t        snap_val;
  logic           snap_load;
  logic           take;
  weight_t        best_val_d;
  digit_idx_t     best_idx_d;

  assign snap_load = (state_q == IDLE) && start;

  digit_decider_snapshot u_snapshot (
    .clk       (clk),
    .n_rst     (n_rst),
    .load_i    (snap_load),
    .data_i    (digit_weights),
    .rd_idx_i  (idx_q),
    .rd_data_o (snap_val)
  );

  // The final digit's comparison is folded straight into the result registers.
  assign take       = takes_lead(snap_val, best_val_q, idx_q == '0);
  assign best_val_d = take ? snap_val : best_val_q;
  assign best_idx_d = take ? idx_q    : best_idx_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      thr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digit_q    <= '0;
      conf_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= SCAN;
            thr_q      <= threshold;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          best_val_q <= best_val_d;
          best_idx_q <= best_idx_d;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            digit_q <= best_idx_d;
            conf_q  <= best_val_d;
            valid_q <= (best_val_d >= thr_q);
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign digit      = digit_q;
  assign confidence = conf_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_digit_decider.sv
// Bench for digit_decider: argmax reference model checked every cycle, plus directed literal cases.
module tb_digit_decider;
  import digit_decider_pkg::*;

  logic                                clk = 1'b0;
  logic                                n_rst;
  logic                                start;
  logic [0:NUM_DIGITS-1][WEIGHT_W-1:0] digit_weights;
  logic [WEIGHT_W-1:0]                 threshold;
  logic                                busy;
  logic                                done;
  logic [IDX_W-1:0]                    digit;
  logic [WEIGHT_W-1:0]                 confidence;
  logic                                valid;

  digit_decider dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .digit_weights (digit_weights),
    .threshold     (threshold),
    .busy          (busy),
    .done          (done),
    .digit         (digit),
    .confidence    (confidence),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a decision takes NUM_DIGITS edges after acceptance, result is the
  // first index holding the maximum of the captured weights, then one more edge to idle.
  int m_busy, m_cnt, m_done, m_digit, m_conf, m_valid, m_thr;
  int m_snap[NUM_DIGITS];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy = 0; m_cnt = 0; m_done = 0; m_digit = 0; m_conf = 0; m_valid = 0; m_thr = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (start) begin
          for (int i = 0; i < NUM_DIGITS; i++) m_snap[i] = int'(digit_weights[i]);
          m_thr  = int'(threshold);
          m_busy = 1;
          m_cnt  = 0;
        end
      end else if (m_cnt < NUM_DIGITS) begin
        m_cnt++;
        if (m_cnt == NUM_DIGITS) begin
          int best;
          best = 0;
          for (int i = 1; i < NUM_DIGITS; i++) if (m_snap[i] > m_snap[best]) best = i;
          m_digit = best;
          m_conf  = m_snap[best];
          m_valid = (m_conf >= m_thr) ? 1 : 0;
          m_done  = 1;
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",       int'(busy),       m_busy);
      check("done",       int'(done),       m_done);
      check("digit",      int'(digit),      m_digit);
      check("confidence", int'(confidence), m_conf);
      check("valid",      int'(valid),      m_valid);
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Called at a falling edge; start is sampled at the next rising edge (E).
  // k counts falling edges after E-... : falling edge k follows rising edge E+k-1.
  task automatic run_decision(input logic [0:NUM_DIGITS-1][WEIGHT_W-1:0] w, input int thr,
                              input int mut_k, input int mut_idx, input int mut_val,
                              input int s2a, input int s2b, output int lat, output int dones);
    int d0;
    d0 = done_cnt;
    digit_weights = w;
    threshold     = WEIGHT_W'(thr);
    start         = 1'b1;
    lat           = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == s2a || k == s2b);
      if (k == mut_k) digit_weights[mut_idx] = WEIGHT_W'(mut_val);
      if (done === 1'b1 && lat < 0) lat = k - 1;
      if (lat >= 0 && k == lat + 2) break;
    end
    start = 1'b0;
    dones = done_cnt - d0;
  endtask

  task automatic expect_result(input string tag, input int lat, input int dones,
                               input int e_digit, input int e_conf, input int e_valid);
    check({tag, " latency"},    lat,              10);
    check({tag, " done_pulses"}, dones,           1);
    check({tag, " digit"},      int'(digit),      e_digit);
    check({tag, " confidence"}, int'(confidence), e_conf);
    check({tag, " valid"},      int'(valid),      e_valid);
    check({tag, " busy_after"}, int'(busy),       0);
  endtask

  initial begin
    int lat, dones, d0;
    logic [0:NUM_DIGITS-1][WEIGHT_W-1:0] w;

    n_rst = 1'b0; start = 1'b0; digit_weights = '0; threshold = '0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy",  int'(busy),       0);
    check("reset done",  int'(done),       0);
    check("reset digit", int'(digit),      0);
    check("reset conf",  int'(confidence), 0);
    check("reset valid", int'(valid),      0);
    n_rst = 1'b1;
    @(negedge clk);

    w = {4'd1, 4'd3, 4'd2, 4'd9, 4'd4, 4'd0, 4'd0, 4'd7, 4'd5, 4'd6};
    run_decision(w, 8, 0, 0, 0, 0, 0, lat, dones);
    expect_result("basic", lat, dones, 3, 9, 1);

    w = {4'd2, 4'd7, 4'd7, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
    run_decision(w, 8, 0, 0, 0, 0, 0, lat, dones);
    expect_result("tie", lat, dones, 1, 7, 0);

    w = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
    run_decision(w, 5, 2, 0, 15, 0, 0, lat, dones);
    expect_result("snapshot", lat, dones, 9, 5, 1);

    w = {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    run_decision(w, 4, 0, 0, 0, 3, 10, lat, dones);
    expect_result("start_busy", lat, dones, 0, 4, 1);

    w = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd15};
    run_decision(w, 15, 0, 0, 0, 0, 0, lat, dones);
    expect_result("back_to_back", lat, dones, 9, 15, 1);

    // Abort mid-scan: reset lands after rising edge E+3.
    w = {4'd9, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    digit_weights = w; threshold = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("abort busy",  int'(busy),       0);
    check("abort done",  int'(done),       0);
    check("abort digit", int'(digit),      0);
    check("abort conf",  int'(confidence), 0);
    check("abort valid", int'(valid),      0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    check("abort no_done", done_cnt - d0, 0);

    run_decision('0, 0, 0, 0, 0, 0, 0, lat, dones);
    expect_result("zero_thr0", lat, dones, 0, 0, 1);
    run_decision('0, 1, 0, 0, 0, 0, 0, lat, dones);
    expect_result("zero_thr1", lat, dones, 0, 0, 0);

    // Random phase: start held or pulsed, weights and threshold churning, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      if (n_rst == 1'b0) n_rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) n_rst = 1'b0;
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          digit_weights[i] = ($urandom_range(0, 1) == 1) ? WEIGHT_W'($urandom_range(0, 15))
                                                          : WEIGHT_W'($urandom_range(0, 2));
        threshold = WEIGHT_W'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    #2 n_rst = 1'b1; start = 1'b0;
    repeat (15) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
